ntt_dual_mode_addr_gen: RTL and testbench
=========================================

// Module: ntt_dual_mode_addr_gen
// PURPOSE
//  Parametrised control/address generator for the PE-array NTT datapath. Runs RING_DEPTH butterfly
//  stages of 2^L loop iterations each, where L = RING_DEPTH-PE_DEPTH-1, in forward (NTT) or inverse
//  (INTT) order. Drives ping-pong BRAM read/write addresses, twiddle ROM address, write enables and
//  PE-shuffle select. Adds mode select, busy/done handshake and compile-time geometry.
// PARAMETERS
//  RING_DEPTH  12  log2(ring size N)
//  PE_DEPTH    3   log2(PE count); require RING_DEPTH-PE_DEPTH-1 >= 1
//  WAIT_CYCLES 16  idle cycles between stages (pipeline flush); require >= WR_DELAY+2
//  WR_DELAY    10  read-to-write latency of PE pipeline (mult + modred + stage regs)
//  (derived) L = RING_DEPTH-PE_DEPTH-1; AW = L+1; SW = $clog2(RING_DEPTH); TW = 1+SW+L
// PORTS
//  clk           in   1    clock
//  reset         in   1    synchronous, active-high reset
//  start         in   1    begin transform; sampled only in IDLE
//  mode          in   1    0 = NTT, 1 = INTT; captured with start
//  busy          out  1    high from cycle after accepted start until done
//  done          out  1    one-cycle pulse at completion
//  raddr         out  AW   {bank, addr} read address
//  raddr_tw      out  TW   twiddle ROM address
//  waddr0        out  AW   even-output write address
//  waddr1        out  AW   odd-output write address
//  wen0          out  1    even write enable
//  wen1          out  1    odd write enable
//  brsel0        out  1    PE shuffle select (even path)
//  brsel1        out  1    PE shuffle select (odd path)
//  stage_count   out  5    effective stage e, aligned with odd write
// BEHAVIOUR
//  Reset: state = IDLE; all outputs and internal counters 0; delay-line contents cleared.
//  Reset wins over start and over any in-flight transform.
//  FSM: IDLE -(start)-> RUN; RUN -(c == 2^L-1)-> WAIT; WAIT -(w == WAIT_CYCLES-1)-> RUN if s < RING_DEPTH-1, else IDLE.
//  start/mode ignored while busy; start and reset in the same cycle: reset wins.
//  Counters: s = stage 0..RING_DEPTH-1; c = loop 0..2^L-1; w = wait count. All zeroed on entering RUN.
//  Effective stage: e = s (NTT), e = RING_DEPTH-1-s (INTT).
//  Read address: t = L-1-e.
//    e < L:  addr = (c>>1) + ((c>>(t+1))<<t) + (c[0] ? 1<<t : 0)
//    e >= L: addr = c
//  Bank: read bank starts at 0 and toggles after every stage; write bank = ~read bank.
//  Twiddle: raddr_tw = {mode_q, e[SW-1:0], c[L-1:0]}; each stage owns 2^L ROM entries.
//  Write addresses:
//    waddr0: addr_e = (c>>1) + ((c>>(t+1))<<t) for e < L, else c.
//    waddr1: addr_e + (1<<t) for e < L, else c.
//  Timing:
//    raddr, raddr_tw registered: valid 1 cycle after the RUN cycle holding c.
//    waddr0/wen0/brsel0 = WR_DELAY cycles after raddr; waddr1/wen1/brsel1/stage_count = WR_DELAY+1.
//    wen = 1 exactly for RUN cycles (delayed); brsel = c[0] (delayed).
//  Handshake:
//    busy rises 1 cycle after accepted start.
//    Total busy = RING_DEPTH*(2^L+WAIT_CYCLES) cycles.
//    done pulses in the first IDLE cycle, and busy is 0 in that cycle.
//    start may be high in the done cycle and is accepted.
//  Widths: all address arithmetic truncates to L bits. Shift amounts never exceed L.
//  No wrap between stages: c saturates at 2^L-1 until WAIT.
// TESTING (RING_DEPTH=5, PE_DEPTH=1, WAIT_CYCLES=16, WR_DELAY=10 -> L=3)
//  NTT stage 0: start, mode=0 -> raddr addr seq 0,4,1,5,2,6,3,7, bank 0; waddr0 0,0,1,1,..; waddr1 4,4,5,5,..
//  NTT stage 1: raddr 0,2,1,3,4,6,5,7, bank 1; stages 2..4: raddr 0..7 in order; raddr_tw e field = stage.
//  INTT, mode=1: stage 0 uses e=4 (raddr 0..7), last stage e=0 (0,4,1,5,..); raddr_tw MSB = 1 throughout.
//  Handshake: busy high exactly 120 cycles, done one pulse; start pulsed mid-run -> no effect on sequence.
//  Latency: wen0 rises 11 cycles after first RUN cycle, wen1 12; each high 8 cycles per stage, 5 bursts.
//  Reset during stage 2 RUN -> next cycle all outputs 0, IDLE; fresh start reproduces the stage-0 sequence exactly.

Source files
------------

// File: rtl/ntt_dual_mode_addr_gen.sv
// Address/control generator for the PE-array NTT datapath: sequences RING_DEPTH butterfly stages
// of 2^L iterations in NTT or INTT order, driving ping-pong BRAM, twiddle ROM and PE shuffle.
`timescale 1ns/1ps
module ntt_dual_mode_addr_gen #(
  parameter int RING_DEPTH  = 12,
  parameter int PE_DEPTH    = 3,
  parameter int WAIT_CYCLES = 16,
  parameter int WR_DELAY    = 10,
  localparam int L  = RING_DEPTH - PE_DEPTH - 1,
  localparam int AW = L + 1,
  localparam int SW = $clog2(RING_DEPTH),
  localparam int TW = 1 + SW + L
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] raddr,
  output logic [TW-1:0] raddr_tw,
  output logic [AW-1:0] waddr0,
  output logic [AW-1:0] waddr1,
  output logic          wen0,
  output logic          wen1,
  output logic          brsel0,
  output logic          brsel1,
  output logic [4:0]    stage_count
);

  localparam int WW = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_WAIT = 2'd2} state_t;

  typedef struct packed {
    logic         wen;
    logic         brsel;
    logic         bank;
    logic [L-1:0] a0;
    logic [L-1:0] a1;
    logic [4:0]   e;
  } pipe_t;

  localparam pipe_t PIPE_CLR = {1'b0, 1'b0, 1'b0, {L{1'b0}}, {L{1'b0}}, 5'd0};

  state_t        state_r;
  logic [4:0]    s_r;
  logic [L-1:0]  c_r;
  logic [WW-1:0] w_r;
  logic          mode_r;
  logic          bank_r;
  logic          busy_r;
  logic          done_r;
  logic [AW-1:0] raddr_r;
  logic [TW-1:0] raddr_tw_r;
  pipe_t         pipe_r [0:WR_DELAY+1];

  logic [4:0]    e_s;
  logic [4:0]    t_s;
  logic [L-1:0]  one_t_s;
  logic [L-1:0]  base_s;
  logic [L-1:0]  rd_s;
  logic [L-1:0]  odd_s;
  pipe_t         pipe_in_s;

  // Effective stage and butterfly addresses for the current loop index
  always_comb begin
    e_s       = mode_r ? (5'(RING_DEPTH - 1) - s_r) : s_r;
    t_s       = 5'd0;
    one_t_s   = {L{1'b0}};
    base_s    = c_r;
    rd_s      = c_r;
    odd_s     = c_r;
    pipe_in_s = PIPE_CLR;
    if (e_s < 5'(L)) begin
      t_s     = 5'(L - 1) - e_s;
      one_t_s = L'(1'b1) << t_s;
      base_s  = (c_r >> 1'b1) + ((c_r >> (t_s + 5'd1)) << t_s);
      rd_s    = base_s + (c_r[0] ? one_t_s : {L{1'b0}});
      odd_s   = base_s + one_t_s;
    end else begin
      base_s  = c_r;
      rd_s    = c_r;
      odd_s   = c_r;
    end
    if (state_r == ST_RUN) begin
      pipe_in_s = {1'b1, c_r[0], ~bank_r, base_s, odd_s, e_s};
    end else begin
      pipe_in_s = PIPE_CLR;
    end
  end

  // Stage/loop/wait sequencing, handshake and registered read addresses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      s_r        <= 5'd0;
      c_r        <= {L{1'b0}};
      w_r        <= {WW{1'b0}};
      mode_r     <= 1'b0;
      bank_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      raddr_r    <= {AW{1'b0}};
      raddr_tw_r <= {TW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= ST_RUN;
            mode_r  <= mode;
            s_r     <= 5'd0;
            c_r     <= {L{1'b0}};
            w_r     <= {WW{1'b0}};
            bank_r  <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          raddr_r    <= {bank_r, rd_s};
          raddr_tw_r <= {mode_r, e_s[SW-1:0], c_r};
          // c holds at its last value through WAIT; no wrap into the next stage
          if (c_r == {L{1'b1}}) begin
            state_r <= ST_WAIT;
            w_r     <= {WW{1'b0}};
          end else begin
            c_r <= c_r + L'(1'b1);
          end
        end
        ST_WAIT: begin
          if (w_r == WW'(WAIT_CYCLES - 1)) begin
            if (s_r < 5'(RING_DEPTH - 1)) begin
              state_r <= ST_RUN;
              s_r     <= s_r + 5'd1;
              c_r     <= {L{1'b0}};
              w_r     <= {WW{1'b0}};
              bank_r  <= ~bank_r;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else begin
            w_r <= w_r + WW'(1'b1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Delay line matching the PE pipeline read-to-write latency
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= WR_DELAY + 1; i++) pipe_r[i] <= PIPE_CLR;
    end else begin
      pipe_r[0] <= pipe_in_s;
      for (int i = 1; i <= WR_DELAY + 1; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign raddr       = raddr_r;
  assign raddr_tw    = raddr_tw_r;
  assign waddr0      = {pipe_r[WR_DELAY].bank, pipe_r[WR_DELAY].a0};
  assign wen0        = pipe_r[WR_DELAY].wen;
  assign brsel0      = pipe_r[WR_DELAY].brsel;
  assign waddr1      = {pipe_r[WR_DELAY+1].bank, pipe_r[WR_DELAY+1].a1};
  assign wen1        = pipe_r[WR_DELAY+1].wen;
  assign brsel1      = pipe_r[WR_DELAY+1].brsel;
  assign stage_count = pipe_r[WR_DELAY+1].e;

endmodule

// File: tb/tb_ntt_dual_mode_addr_gen.sv
// Bench for ntt_dual_mode_addr_gen at RING_DEPTH=5, PE_DEPTH=1 (L=3): randomized handshake
// timing checked cycle by cycle against a butterfly-pair reference model.
`timescale 1ns/1ps
module tb_ntt_dual_mode_addr_gen;

  localparam int RD = 5, PD = 1, WC = 16, WD = 10;
  localparam int L = RD - PD - 1;
  localparam int SW = $clog2(RD);
  localparam int NC = 1 << L;
  localparam int SL = NC + WC;
  localparam int TOTAL = RD * SL;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0;
  logic busy, done, wen0, wen1, brsel0, brsel1;
  logic [L:0] raddr, waddr0, waddr1;
  logic [L+SW:0] raddr_tw;
  logic [4:0] stage_count;

  int total_cnt = 0, pass_cnt = 0, fail_cnt = 0;

  ntt_dual_mode_addr_gen #(.RING_DEPTH(RD), .PE_DEPTH(PD), .WAIT_CYCLES(WC), .WR_DELAY(WD)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .busy(busy), .done(done),
    .raddr(raddr), .raddr_tw(raddr_tw), .waddr0(waddr0), .waddr1(waddr1),
    .wen0(wen0), .wen1(wen1), .brsel0(brsel0), .brsel1(brsel1), .stage_count(stage_count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  // Butterfly pair (lo, hi) for loop index c at effective stage e; read picks hi on odd c.
  task automatic model(input int e, input int c, output int rd, output int lo, output int hi);
    int t, j;
    if (e < L) begin
      t  = L - 1 - e;
      j  = c / 2;
      lo = ((j >> t) << (t + 1)) | (j & ((1 << t) - 1));
      hi = lo + (1 << t);
      rd = (c % 2 == 1) ? hi : lo;
    end else begin
      lo = c; hi = c; rd = c;
    end
  endtask

  function automatic bit is_run(input int m);
    return (m >= 0) && (m < TOTAL) && ((m % SL) < NC);
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 0, 32'(busy), 32'd0);
    chk({tag, "_done"}, 0, 32'(done), 32'd0);
    chk({tag, "_raddr"}, 0, 32'(raddr), 32'd0);
    chk({tag, "_raddr_tw"}, 0, 32'(raddr_tw), 32'd0);
    chk({tag, "_waddr0"}, 0, 32'(waddr0), 32'd0);
    chk({tag, "_waddr1"}, 0, 32'(waddr1), 32'd0);
    chk({tag, "_wen0"}, 0, 32'(wen0), 32'd0);
    chk({tag, "_wen1"}, 0, 32'(wen1), 32'd0);
    chk({tag, "_brsel0"}, 0, 32'(brsel0), 32'd0);
    chk({tag, "_brsel1"}, 0, 32'(brsel1), 32'd0);
    chk({tag, "_stage"}, 0, 32'(stage_count), 32'd0);
  endtask

  // One full transform; n = 0 is the first RUN cycle. A start pulse at pulse_at must be ignored.
  task automatic run_check(input logic m, input int pulse_at, input logic pulse_mode);
    int s, c, e, rd, lo, hi, p;
    @(negedge clk); start = 1'b1; mode = m;
    @(negedge clk); start = 1'b0; mode = ~m;
    for (int n = 0; n <= TOTAL + 10; n++) begin
      chk("busy", n, 32'(busy), 32'(n < TOTAL));
      chk("done", n, 32'(done), 32'(n == TOTAL));
      p = n - 1;
      if (is_run(p)) begin
        s = p / SL; c = p % SL; e = m ? (RD - 1 - s) : s;
        model(e, c, rd, lo, hi);
        chk("raddr", n, 32'(raddr), 32'((s % 2) * NC + rd));
        chk("raddr_tw", n, 32'(raddr_tw), 32'(int'(m) * (RD' (0) + (1 << (SW + L))) + e * NC + c));
      end
      p = n - 1 - WD;
      chk("wen0", n, 32'(wen0), 32'(is_run(p)));
      if (is_run(p)) begin
        s = p / SL; c = p % SL; e = m ? (RD - 1 - s) : s;
        model(e, c, rd, lo, hi);
        chk("waddr0", n, 32'(waddr0), 32'((1 - s % 2) * NC + lo));
        chk("brsel0", n, 32'(brsel0), 32'(c % 2));
      end
      p = n - 2 - WD;
      chk("wen1", n, 32'(wen1), 32'(is_run(p)));
      if (is_run(p)) begin
        s = p / SL; c = p % SL; e = m ? (RD - 1 - s) : s;
        model(e, c, rd, lo, hi);
        chk("waddr1", n, 32'(waddr1), 32'((1 - s % 2) * NC + hi));
        chk("brsel1", n, 32'(brsel1), 32'(c % 2));
        chk("stage_count", n, 32'(stage_count), 32'(e));
      end
      start = (n == pulse_at) ? 1'b1 : 1'b0;
      mode  = (n == pulse_at) ? pulse_mode : ~m;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int rst_at;
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 0, 32'(busy), 32'd0);

    run_check(1'b0, int'($urandom_range(1, 100)), 1'($urandom));
    repeat ($urandom_range(0, 3)) @(negedge clk);
    run_check(1'b1, int'($urandom_range(1, 100)), 1'($urandom));

    // Reset during a stage-2 RUN cycle, then a fresh NTT must replay from stage 0.
    rst_at = int'($urandom_range(2 * SL, 2 * SL + NC - 1));
    @(negedge clk); start = 1'b1; mode = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (rst_at) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", 0, 32'(busy), 32'd0);
    run_check(1'b0, int'($urandom_range(1, 100)), 1'b1);

    // Start coinciding with reset must be dropped.
    @(negedge clk); reset = 1'b1; start = 1'b1;
    @(negedge clk); reset = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start_busy", 0, 32'(busy), 32'd0);
    chk("rst_start_wen0", 0, 32'(wen0), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
